mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO) in the execute stage, owning the HI/LO registers.
- Its registered `busy` output is combined by hazard logic into the `en` (stall) and `clear` (bubble) controls of the surrounding enable/clear pipeline registers.
- While it runs, the pipeline stages upstream of execute are held.

Parameters:
- W, 32, operand width; also the number of iterations per operation.
- CW, 6, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high; sampled only at the rising edge of clk.
- start  input  1  request a new operation this cycle.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  W  operand rs; dividend for DIV/DIVU.
- b  input  W  operand rt; divisor for DIV/DIVU.
- flush  input  1  abort the operation in flight (branch/exception squash).
- mthi  input  1  write `wdata` into HI.
- mtlo  input  1  write `wdata` into LO.
- wdata  input  W  data for MTHI/MTLO.
- hi  output  W  HI register.
- lo  output  W  LO register.
- busy  output  1  registered; high while an operation is in progress.
- done  output  1  registered one-cycle pulse after HI/LO are updated by an operation.

Behaviour:
- Reset (synchronous), at the clk edge where reset=1:
  - state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
  - Overrides every other input, including mid-operation; no partial result is written.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge t: latch op plus operand magnitudes (|a|, |b| for signed ops) and result-sign flags; go to RUN; counter=0.
  - Otherwise stay in IDLE.
- RUN:
  - One iteration per cycle.
  - Multiply: radix-2 shift-add into a 2W-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - Counter increments each cycle; after W iterations (edge t+W) go to FIX.
- FIX:
  - Apply the sign correction.
  - Signed multiply: negate the 2W product if the operand signs differ.
  - Signed divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Write {hi,lo}: the product, or hi=remainder and lo=quotient.
  - At edge t+W+1 go to IDLE; done=1 for the following cycle.
- busy timing:
  - busy = (state != IDLE), registered.
  - High for exactly W+1 cycles, from after edge t through edge t+W+1.
  - Hazard logic must stall any MFHI/MFLO/start while busy=1.
- Ignored inputs: start while busy=1 is ignored and op/operands are not relatched. mthi/mtlo while busy=1 are ignored.
- Priority when not busy:
  - Order is reset > flush > start > mthi/mtlo.
  - If start and mthi/mtlo coincide, the write happens and the operation is also accepted; the operation result later overwrites HI/LO.
- flush=1 while busy: next state IDLE; hi/lo unchanged; no done pulse; busy=0 after that edge.
- flush=1 while IDLE: blocks start in the same cycle.
- Division by zero (signed and unsigned): lo = all ones, hi = a as originally presented. Still takes W+1 cycles.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Arithmetic: internal datapath is 2W bits for products. Unsigned ops use the operands directly with no sign handling.

Test Plan:
- Reset then MULT with a=0xFFFFFFFD (−3), b=5 → busy high exactly 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU with a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV with a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/7 → lo=14, hi=2.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234 then MTLO 0x5678 while idle → hi=0x1234, lo=0x5678. Then start MULT 2×3 and assert flush at cycle 10 → busy=0 next cycle; no done; hi/lo still 0x1234/0x5678.
- start held high, plus mthi, during a DIVU 9/4 → only one operation; mthi ignored; lo=2, hi=1.
- Assert reset at cycle 15 of a MULT → hi=lo=0 and busy=0 after that edge; a start on the next cycle completes correctly.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restore step per cycle, then a single sign-fix cycle.
module mul_div_unit #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
    return ~x + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mag_b_q, mag_b_d;
  logic           is_div_q, is_div_d;
  logic           neg_q, neg_d;
  logic           neg_rem_q, neg_rem_d;
  logic           bzero_q, bzero_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q;
  logic           done_q, done_d;

  logic           sgn_a_s, sgn_b_s;
  logic [W:0]     mul_sum_s;
  logic [W:0]     trial_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s;

  assign sgn_a_s = ~op[0] & a[W-1];
  assign sgn_b_s = ~op[0] & b[W-1];

  // Multiply step adds the multiplicand into the upper half when the LSB is set;
  // divide step trial-subtracts the divisor from the shifted partial remainder.
  assign mul_sum_s = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_b_q} : {(W+1){1'b0}});
  assign trial_s   = acc_q[2*W-1:W-1] - {1'b0, mag_b_q};
  assign prod_s    = neg_q ? neg_2w(acc_q) : acc_q;
  assign quo_s     = neg_q ? neg_w(acc_q[W-1:0]) : acc_q[W-1:0];
  assign rem_s     = neg_rem_q ? neg_w(acc_q[2*W-1:W]) : acc_q[2*W-1:W];

  // Next-state, datapath step and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && start) begin
          state_d   = RUN;
          cnt_d     = {CW{1'b0}};
          acc_d     = {{W{1'b0}}, (sgn_a_s ? neg_w(a) : a)};
          mag_b_d   = sgn_b_s ? neg_w(b) : b;
          is_div_d  = op[1];
          neg_d     = sgn_a_s ^ sgn_b_s;
          neg_rem_d = sgn_a_s;
          bzero_d   = (b == {W{1'b0}});
        end else begin
          state_d = IDLE;
        end
        if (mthi) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (mtlo) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (is_div_q) begin
            acc_d = trial_s[W] ? {acc_q[2*W-2:0], 1'b0}
                               : {trial_s[W-1:0], acc_q[W-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum_s, acc_q[W-1:1]};
          end
          if (cnt_q == CW'(W - 1)) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (flush) begin
          done_d = 1'b0;
        end else if (is_div_q) begin
          done_d = 1'b1;
          hi_d   = rem_s;
          lo_d   = bzero_q ? {W{1'b1}} : quo_s;
        end else begin
          done_d = 1'b1;
          hi_d   = prod_s[2*W-1:W];
          lo_d   = prod_s[W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      acc_q     <= {(2*W){1'b0}};
      mag_b_q   <= {W{1'b0}};
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= {W{1'b0}};
      lo_q      <= {W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at issue, popped at done.
module tb_mul_div_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, flush, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mul_div_unit #(.W(W), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: p = 64'(longint'(sx) * longint'(sy));
      2'd1: p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else if (o == 2'd2) p = {32'(sx % sy), 32'(sx / sy)};
        else p = {x % y, x / y};
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    sb_q.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [W-1:0] h, output logic [W-1:0] l,
                           output int busy_cnt, output bit timeout);
    busy_cnt = busy ? 1 : 0;
    timeout  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy) busy_cnt++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
    h = hi;
    l = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy, done} !== {64'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all zero", hi, lo, busy, done);
    end
  endtask

  task automatic test_mult_timing();
    logic [W-1:0] h, l;
    int bc;
    bit to;
    exp_t e;
    drive_op(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(h, l, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || bc != 33) begin
      errors++;
      $display("FAIL mult_busy_len: busy cycles %0d timeout %0d, want 33 and no timeout", bc, to);
    end
    checks++;
    if ({h, l} !== {e.hi, e.lo} || {h, l} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++;
      $display("FAIL mult_neg3x5: got %h_%h want FFFFFFFF_FFFFFFF1", h, l);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_arith();
    logic [1:0]   t_op[7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [W-1:0] t_a[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5,
                              32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
    logic [W-1:0] t_b[7]  = '{32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0,
                              32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    logic [63:0]  t_x[7]  = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0002_0000_000E, 64'h0000_0005_FFFF_FFFF,
                              64'h0000_0000_8000_0000, 64'hFFFF_FFFB_FFFF_FFFF,
                              64'h4000_0000_0000_0000};
    logic [W-1:0] h, l;
    int bc;
    bit to;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive_op(t_op[i], t_a[i], t_b[i]);
      wait_done(h, l, bc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || {h, l} !== t_x[i] || {e.hi, e.lo} !== t_x[i] || bc != 33) begin
        errors++;
        $display("FAIL arith_%0d op=%0d a=%h b=%h: got %h_%h busy=%0d to=%0d want %h",
                 i, t_op[i], t_a[i], t_b[i], h, l, bc, to, t_x[i]);
      end
      step();
    end
  endtask

  task automatic test_mt_flush();
    mthi = 1'b1; wdata = 32'h1234;
    step();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    step();
    mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1234, 32'h5678}) begin
      errors++;
      $display("FAIL mthi_mtlo: got %h/%h want 1234/5678", hi, lo);
    end
    op = 2'd0; a = 32'd2; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hBAD0_BAD0;
    repeat (8) step();
    mthi = 1'b0; mtlo = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) break;
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== {32'h1234, 32'h5678}) begin
      errors++;
      $display("FAIL flush_hold: done=%b busy=%b hi=%h lo=%h want 0 0 1234 5678", done, busy, hi, lo);
    end
    flush = 1'b1; start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    step();
    flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] h, l;
    int bc;
    bit to;
    exp_t e;
    sb_q.push_back(model(2'd3, 32'd9, 32'd4));
    op = 2'd3; a = 32'd9; b = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    a = 32'd100; b = 32'd3; op = 2'd0;
    wait_done(h, l, bc, to);
    start = 1'b0; mthi = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (to || {h, l} !== {e.hi, e.lo} || {h, l} !== {32'd1, 32'd2} || bc != 33) begin
      errors++;
      $display("FAIL start_held_divu: got %h/%h busy=%0d to=%0d want 1/2 busy=33", h, l, bc, to);
    end
    step();
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== {32'd1, 32'd2}) begin
      errors++;
      $display("FAIL start_held_single: busy=%b hi=%h lo=%h want 0 1 2", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] h, l;
    int bc;
    bit to;
    exp_t e;
    op = 2'd0; a = 32'd7; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy, done} !== {64'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b want zeros", hi, lo, busy, done);
    end
    drive_op(2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
    wait_done(h, l, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {h, l} !== {e.hi, e.lo} || {h, l} !== 64'd12) begin
      errors++;
      $display("FAIL after_reset_mult: got %h_%h to=%0d want 0_c", h, l, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h, l, x, y;
    logic [1:0] o;
    int bc;
    bit to;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      y = (i % 4 == 3) ? 32'($urandom_range(0, 20)) : $urandom();
      drive_op(o, x, y);
      wait_done(h, l, bc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || {h, l} !== {e.hi, e.lo}) begin
        errors++;
        $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h_%h to=%0d want %h_%h",
                 i, o, x, y, h, l, to, e.hi, e.lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_arith();
    test_mt_flush();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
